ddr_wb_arbiter: RTL and testbench

- Shares the single DDR Wishbone master port between NUM_MASTERS cache refill/writeback engines (ICache, DCache, later DMA).
- Round-robin grant, held for the whole cyc, with a watchdog that aborts hung bus cycles.
- Runs in the clkDDR domain; replaces the free-running toggle arbiter in the CPU/cache top level.

---
 rtl/ddr_wb_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/ddr_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_ddr_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_wb_pkg.sv
// Shared definitions for the DDR Wishbone arbiter: state encoding, bus widths, watchdog default.
package ddr_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arbState_e;

  localparam int unsigned DDR_ADDR_W  = 32;
  localparam int unsigned DDR_DATA_W  = 512;
  localparam int unsigned DDR_DM_W    = DDR_DATA_W / 8;
  localparam int unsigned DDR_TIMEOUT = 1023;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after the previous winner, returned one-hot.
module rr_pick #(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] last,
  output logic [NUM_MASTERS-1:0] nextGrant
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] candIdx;
  logic             found;

  // Scan from last+1 around the ring; the previous winner is checked last.
  always_comb begin
    lastIdx   = '0;
    nextGrant = '0;
    candIdx   = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (last[i]) lastIdx = IDX_W'(i);
    end
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      candIdx = IDX_W'((32'(lastIdx) + k) % NUM_MASTERS);
      if (!found && req[candIdx]) begin
        nextGrant[candIdx] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_wb_arbiter.sv
// Round-robin arbiter sharing the DDR Wishbone port between cache engines, with a stall watchdog.
module ddr_wb_arbiter
  import ddr_wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = DDR_ADDR_W,
  parameter int unsigned DATA_W      = DDR_DATA_W,
  parameter int unsigned TIMEOUT     = DDR_TIMEOUT
) (
  input  logic                            clkDDR,
  input  logic                            rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dout,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_dm,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  output logic [DATA_W-1:0]               m_din,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_dout,
  output logic [DATA_W/8-1:0]             s_dm,
  output logic                            s_we,
  output logic                            s_cyc,
  output logic                            s_stb,
  input  logic [DATA_W-1:0]               s_din,
  input  logic                            s_ack,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            timeout_flag
);

  localparam int unsigned DM_W   = DATA_W / 8;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

  arbState_e               state;
  logic [NUM_MASTERS-1:0]  grant;
  logic [NUM_MASTERS-1:0]  lastGrant;
  logic [NUM_MASTERS-1:0]  pickGrant;
  logic [WDOG_W-1:0]       wdog;
  logic                    timeoutFlag;
  logic                    busy;
  logic                    grantCyc;
  logic                    grantStb;
  logic                    grantWe;
  logic                    wdogExpire;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) uPick (
    .req       (m_cyc),
    .last      (lastGrant),
    .nextGrant (pickGrant)
  );

  // Route the granted master onto the DDR port; acks/errors go back only to the owner.
  always_comb begin
    busy     = (state == BUSY) && !rst;
    grantCyc = |(grant & m_cyc);
    grantStb = |(grant & m_stb);
    grantWe  = |(grant & m_we);
    s_addr   = '0;
    s_dout   = '0;
    s_dm     = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        s_addr = m_addr[i*ADDR_W +: ADDR_W];
        s_dout = m_dout[i*DATA_W +: DATA_W];
        s_dm   = m_dm[i*DM_W +: DM_W];
      end
    end
    s_cyc      = busy && grantCyc;
    s_stb      = s_cyc && grantStb;
    s_we       = busy && grantWe;
    m_ack      = (s_ack && s_cyc) ? grant : '0;
    m_err      = ((state == ABORT) && !rst) ? grant : '0;
    m_din      = s_din;
    wdogExpire = s_stb && !s_ack && (wdog == WDOG_W'(TIMEOUT));
  end

  assign grant_o      = grant;
  assign timeout_flag = timeoutFlag;

  // Arbitration FSM: grant on request, hold until cyc drops, abort on watchdog expiry.
  always_ff @(posedge clkDDR) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      lastGrant   <= {1'b1, {(NUM_MASTERS-1){1'b0}}};
      wdog        <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (|m_cyc) begin
            grant     <= pickGrant;
            lastGrant <= pickGrant;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!grantCyc) begin
            grant <= '0;
            wdog  <= '0;
            state <= IDLE;
          end else if (wdogExpire) begin
            wdog  <= '0;
            state <= ABORT;
          end else if (s_stb && !s_ack) begin
            wdog <= wdog + WDOG_W'(1);
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          grant       <= '0;
          wdog        <= '0;
          timeoutFlag <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          grant <= '0;
          wdog  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wb_arbiter.sv
// Directed bench for ddr_wb_arbiter with a cycle-level ownership model and literal spot checks.
module tb_ddr_wb_arbiter;

  localparam int NM  = 2;
  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int MW  = DW / 8;
  localparam int TMO = 8;

  logic              clkDDR = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_dout;
  logic [NM*MW-1:0]  m_dm;
  logic [NM-1:0]     m_we, m_cyc, m_stb;
  logic [DW-1:0]     m_din;
  logic [NM-1:0]     m_ack, m_err;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_dout;
  logic [MW-1:0]     s_dm;
  logic              s_we, s_cyc, s_stb;
  logic [DW-1:0]     s_din;
  logic              s_ack;
  logic [NM-1:0]     grant_o;
  logic              timeout_flag;

  int vectors     = 0;
  int miscompares = 0;
  bit armed       = 1'b0;

  ddr_wb_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (TMO)
  ) dut (
    .clkDDR       (clkDDR),
    .rst          (rst),
    .m_addr       (m_addr),
    .m_dout       (m_dout),
    .m_dm         (m_dm),
    .m_we         (m_we),
    .m_cyc        (m_cyc),
    .m_stb        (m_stb),
    .m_din        (m_din),
    .m_ack        (m_ack),
    .m_err        (m_err),
    .s_addr       (s_addr),
    .s_dout       (s_dout),
    .s_dm         (s_dm),
    .s_we         (s_we),
    .s_cyc        (s_cyc),
    .s_stb        (s_stb),
    .s_din        (s_din),
    .s_ack        (s_ack),
    .grant_o      (grant_o),
    .timeout_flag (timeout_flag)
  );

  always #5 clkDDR = ~clkDDR;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkDDR);
    #1;
  endtask

  task automatic sample();
    @(negedge clkDDR);
  endtask

  task automatic doReset();
    rst   = 1'b1;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Model state: who owns the port (-1 = nobody), whether the owner is being aborted,
  // stalled-strobe count, last owner for the rotation, and the sticky abort flag.
  int   owner     = -1;
  bit   aborting  = 1'b0;
  int   stall     = 0;
  int   lastOwner = NM - 1;
  bit   flagM     = 1'b0;
  bit   held;
  logic eCyc, eStb, eWe;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eDout;
  logic [MW-1:0] eDm;
  logic [NM-1:0] eAck, eErr, eGrant;
  int   idx;

  // Compare every output against the model mid-cycle, then advance the model to the next edge.
  always @(negedge clkDDR) begin
    if (armed) begin
      held   = (owner >= 0) && !aborting && !rst;
      eAddr  = '0;
      eDout  = '0;
      eDm    = '0;
      eGrant = '0;
      eCyc   = 1'b0;
      eStb   = 1'b0;
      eWe    = 1'b0;
      if (owner >= 0) begin
        eAddr         = m_addr[owner*AW +: AW];
        eDout         = m_dout[owner*DW +: DW];
        eDm           = m_dm[owner*MW +: MW];
        eGrant[owner] = 1'b1;
        if (held) begin
          eCyc = m_cyc[owner];
          eStb = eCyc & m_stb[owner];
          eWe  = m_we[owner];
        end
      end
      eAck = (eCyc && s_ack) ? eGrant : '0;
      eErr = (aborting && !rst) ? eGrant : '0;

      check("s_cyc", DW'(s_cyc), DW'(eCyc));
      check("s_stb", DW'(s_stb), DW'(eStb));
      check("s_we", DW'(s_we), DW'(eWe));
      check("s_addr", DW'(s_addr), DW'(eAddr));
      check("s_dout", s_dout, eDout);
      check("s_dm", DW'(s_dm), DW'(eDm));
      check("m_ack", DW'(m_ack), DW'(eAck));
      check("m_err", DW'(m_err), DW'(eErr));
      check("m_din", m_din, s_din);
      check("grant_o", DW'(grant_o), DW'(eGrant));
      check("timeout_flag", DW'(timeout_flag), DW'(flagM));

      if (rst) begin
        owner = -1; aborting = 1'b0; stall = 0; lastOwner = NM - 1; flagM = 1'b0;
      end else if (aborting) begin
        owner = -1; aborting = 1'b0; stall = 0; flagM = 1'b1;
      end else if (owner < 0) begin
        stall = 0;
        for (int k = 1; k <= NM; k++) begin
          idx = (lastOwner + k) % NM;
          if (owner < 0 && m_cyc[idx]) owner = idx;
        end
        if (owner >= 0) lastOwner = owner;
      end else if (!m_cyc[owner]) begin
        owner = -1; stall = 0;
      end else if (eStb && !s_ack) begin
        if (stall == TMO) begin
          aborting = 1'b1; stall = 0;
        end else begin
          stall++;
        end
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    m_addr = {32'h0000_2000, 32'h0000_1000};
    m_dout = {{16{32'hBBBB_0001}}, {16{32'hAAAA_0000}}};
    m_dm   = {{8{8'h0F}}, {8{8'hFF}}};
    m_we   = 2'b10;
    m_cyc  = '0;
    m_stb  = '0;
    s_din  = {16{32'hDEAD_BEEF}};
    s_ack  = 1'b0;
    tick();
    tick();
    rst   = 1'b0;
    armed = 1'b1;

    // Reset state
    sample();
    check("rst_grant", DW'(grant_o), DW'(2'b00));
    check("rst_scyc", DW'(s_cyc), DW'(1'b0));
    check("rst_flag", DW'(timeout_flag), DW'(1'b0));
    check("rst_saddr", DW'(s_addr), DW'(32'h0));

    // Single request from master0, DDR acks three cycles after s_cyc
    tick(); m_cyc = 2'b01; m_stb = 2'b01;
    sample(); check("single_lat0", DW'(s_cyc), DW'(1'b0));
    tick();
    sample();
    check("single_scyc", DW'(s_cyc), DW'(1'b1));
    check("single_addr", DW'(s_addr), DW'(32'h0000_1000));
    check("single_we", DW'(s_we), DW'(1'b0));
    tick(); tick(); tick(); s_ack = 1'b1;
    sample();
    check("single_ack", DW'(m_ack), DW'(2'b01));
    check("single_din", m_din, {16{32'hDEAD_BEEF}});
    tick(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    sample();
    check("single_ack_pulse", DW'(m_ack), DW'(2'b00));
    check("single_release", DW'(s_cyc), DW'(1'b0));
    tick(); tick();

    // Contention right after reset: master0 first, then master1, then master0 again
    doReset();
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    sample(); check("cont_first", DW'(grant_o), DW'(2'b01));
    tick(); s_ack = 1'b1;
    sample(); check("cont_ack0", DW'(m_ack), DW'(2'b01));
    tick(); s_ack = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
    sample(); check("cont_rel_scyc", DW'(s_cyc), DW'(1'b0));
    tick();
    sample(); check("cont_bubble", DW'(grant_o), DW'(2'b00));
    tick();
    sample();
    check("cont_second", DW'(grant_o), DW'(2'b10));
    check("cont_addr1", DW'(s_addr), DW'(32'h0000_2000));
    check("cont_we1", DW'(s_we), DW'(1'b1));
    tick(); s_ack = 1'b1;
    sample(); check("cont_ack1", DW'(m_ack), DW'(2'b10));
    tick(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick(); m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    sample(); check("cont_alternate", DW'(grant_o), DW'(2'b01));
    tick(); m_cyc = '0; m_stb = '0;
    tick(); tick();

    // Multi-beat hold: master1 keeps the port for three beats while master0 waits
    m_cyc = 2'b10; m_stb = 2'b10;
    tick();
    sample(); check("hold_grant", DW'(grant_o), DW'(2'b10));
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int b = 0; b < 3; b++) begin
      tick(); s_ack = 1'b1;
      sample();
      check("hold_beat_grant", DW'(grant_o), DW'(2'b10));
      check("hold_beat_ack", DW'(m_ack), DW'(2'b10));
      tick(); s_ack = 1'b0;
      sample(); check("hold_gap_ack", DW'(m_ack), DW'(2'b00));
    end
    tick(); m_cyc = 2'b01; m_stb = 2'b01;
    sample(); check("hold_release", DW'(s_cyc), DW'(1'b0));
    tick(); tick();
    sample(); check("hold_next", DW'(grant_o), DW'(2'b01));
    tick(); m_cyc = '0; m_stb = '0;
    tick(); tick();

    // Watchdog: master0 strobes, DDR never acks
    m_cyc = 2'b01; m_stb = 2'b01;
    repeat (10) tick();
    sample();
    check("wd_err", DW'(m_err), DW'(2'b01));
    check("wd_scyc", DW'(s_cyc), DW'(1'b0));
    tick(); m_cyc = '0; m_stb = '0;
    sample();
    check("wd_flag", DW'(timeout_flag), DW'(1'b1));
    check("wd_err_pulse", DW'(m_err), DW'(2'b00));
    check("wd_grant_clr", DW'(grant_o), DW'(2'b00));
    repeat (3) tick();
    sample(); check("wd_flag_sticky", DW'(timeout_flag), DW'(1'b1));

    // Ack arriving exactly when the count reaches TIMEOUT wins over the abort
    m_cyc = 2'b01; m_stb = 2'b01;
    repeat (9) tick(); s_ack = 1'b1;
    sample();
    check("wd_edge_ack", DW'(m_ack), DW'(2'b01));
    check("wd_edge_noerr", DW'(m_err), DW'(2'b00));
    tick(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    sample(); check("wd_edge_noerr2", DW'(m_err), DW'(2'b00));
    tick();
    sample(); check("wd_edge_noerr3", DW'(m_err), DW'(2'b00));

    // Reset while master1 holds the port with stb high
    m_cyc = 2'b10; m_stb = 2'b10;
    tick();
    sample(); check("rmid_grant", DW'(grant_o), DW'(2'b10));
    tick(); rst = 1'b1; s_ack = 1'b1;
    sample();
    check("rmid_scyc", DW'(s_cyc), DW'(1'b0));
    check("rmid_noack", DW'(m_ack), DW'(2'b00));
    tick(); rst = 1'b0; s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    sample();
    check("rmid_grant_clr", DW'(grant_o), DW'(2'b00));
    check("rmid_flag_clr", DW'(timeout_flag), DW'(1'b0));
    tick();
    sample(); check("rmid_first", DW'(grant_o), DW'(2'b01));
    tick(); m_cyc = '0; m_stb = '0;
    tick(); tick();

    // Stray ack while idle
    s_ack = 1'b1;
    sample();
    check("stray_ack", DW'(m_ack), DW'(2'b00));
    check("stray_scyc", DW'(s_cyc), DW'(1'b0));
    tick(); s_ack = 1'b0;
    sample(); check("stray_idle", DW'(grant_o), DW'(2'b00));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL time_limit: got still running, expected finished");
    $fatal(1);
  end

endmodule
